xc_mmul_seq: RTL and testbench
==============================

# xc_mmul_seq

Multi-cycle sequencer for the XCrypt multiply-accumulate datapath (xc.mmul.3: 64-bit rd pair = rs1 * rs2 + rs3, all unsigned). It shares one narrow MUL_W-bit-per-step multiplier slice across 32/MUL_W cycles. It latches operands on a request handshake and holds the 64-bit result until the execute stage consumes it. It sits beside the ALU in the execute stage and is flushed by the pipeline on a kill.

## Interface
- MUL_W, 8, multiplier bits consumed per step. Legal values are 1, 2, 4, 8, 16, 32. Any other value is a compile-time error.
- g_clk  in  1  clock; all state updates on the rising edge
- g_resetn  in  1  asynchronous, active-low reset
- flush  in  1  abandon any in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle (high only in IDLE)
- req_acc  in  1  1: add rs3 (xc.mmul.3); 0: plain 64-bit product, rs3 ignored
- req_rs1  in  32  multiplicand
- req_rs2  in  32  multiplier
- req_rs3  in  32  addend
- rsp_valid  out  1  result valid (DONE state)
- rsp_ready  in  1  consumer takes the result
- rsp_lo  out  32  result[31:0] (rd)
- rsp_hi  out  32  result[63:32] (rd+1)
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: req_ready=1. On req_valid && !flush, go to RUN and load:
    - mcand = {32'b0, rs1} (64-bit)
    - mplier = rs2
    - acc = req_acc ? {32'b0, rs3} : 0
    - cnt = 0
  - RUN: each cycle performs one step:
    - acc += mcand * mplier[MUL_W-1:0]
    - mcand <<= MUL_W
    - mplier >>= MUL_W
    - cnt++
    - When cnt reaches 32/MUL_W-1, the step completes and the state goes to DONE.
  - DONE: rsp_valid=1 and rsp_lo/rsp_hi = acc. On rsp_ready, go to IDLE.
- Arithmetic:
  - All unsigned, modulo 2^64.
  - The maximum true result is 2^64-2^32, so no overflow occurs.
  - The partial product is 32+MUL_W bits, zero-extended to 64 before adding.
- flush: from any state, the next state is IDLE; acc, mcand, mplier and cnt are not cleared.
- A flush in IDLE coincident with req_valid blocks the accept.
- A flush in DONE coincident with rsp_ready: the response is still considered consumed.
- req_ready is only high in IDLE, so there is no accept in DONE; a new request waits one cycle after the response is consumed.
- Operands are sampled only at accept. Changes to req_* while busy are ignored.
- rsp_lo/rsp_hi are stable for the whole time rsp_valid is high.

## Timing
- Reset values:
  - State is IDLE.
  - req_ready=1, rsp_valid=0, busy=0.
  - rsp_lo=0 and rsp_hi=0, since acc resets to 0. mcand, mplier and cnt reset to 0.
- Latency with N = 32/MUL_W:
  - Accept edge at cycle 0.
  - RUN occupies cycles 1..N.
  - rsp_valid is first high in cycle N+1.
  - With MUL_W=8, rsp_valid is first high in cycle 5.
- Throughput: one operation per N+2 cycles when rsp_ready is tied high.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). No response is produced.
- All outputs are decoded from registered state and acc; there is no combinational path from req_* or rsp_ready to any output.

## Configuration
- XC_MMUL_SEQ_EARLY_TERM_EN
  - Defined: in RUN, if the mplier value after the current shift is zero, go to DONE at the end of that step regardless of cnt. rs2=0 therefore takes exactly 1 RUN cycle, and rs2=0x000000FF with MUL_W=8 also takes 1 RUN cycle.
  - Undefined: always exactly N RUN cycles, giving constant-time latency. This is the required setting for side-channel-hardened builds.

## Structure
- Shared package xc_mmul_pkg holds:
  - the state typedef (IDLE/RUN/DONE, 2 bits)
  - the legal-MUL_W check function
  - the localparam computing N and the cnt width, $clog2(N) with a minimum of 1
- One sub-module, xc_mmul_step: combinational, acc_out = acc_in + mcand * mplier_chunk, parameterised by MUL_W. It is instantiated once; the sequencer owns all registers and the FSM.

## Test plan
- MUL_W=8, req_acc=1, rs1=3, rs2=5, rs3=7 -> rsp_valid in cycle 5, hi=0x00000000, lo=0x00000016.
- req_acc=1, rs1=rs2=rs3=0xFFFFFFFF -> hi=0xFFFFFFFF, lo=0x00000000; req_acc=0 with the same operands -> hi=0xFFFFFFFE, lo=0x00000001.
- Hold rsp_ready=0 for 10 cycles after DONE, with req_valid high and req_* changing throughout:
  - rsp_valid stays high with the result unchanged
  - req_ready stays 0
  - the held request is accepted one cycle after rsp_ready.
- flush in RUN cycle 2 -> IDLE the next cycle, rsp_valid never asserts; the next request (rs1=2, rs2=2, rs3=1, acc=1) returns lo=5 with no residue.
- g_resetn pulsed low mid-RUN -> outputs at reset values asynchronously; after release, req_ready=1.
- XC_MMUL_SEQ_EARLY_TERM_EN defined, MUL_W=8, rs2=0x00000001, rs1=0x12345678, rs3=0 -> rsp_valid in cycle 2, lo=0x12345678; the macro undefined gives cycle 5 with the same result.

Source files
------------

// File: rtl/xc_mmul_pkg.sv
// Shared types and sizing helpers for the xc.mmul.3 multi-cycle sequencer.
// Sizing helpers derive the step count and counter width from the slice width.
package xc_mmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic bit mul_w_legal(input int unsigned mul_w);
        return mul_w inside {32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32};
    endfunction

    function automatic int unsigned steps_for(input int unsigned mul_w);
        return 32 / mul_w;
    endfunction

    // A single-step build still needs a 1-bit counter to keep the ports legal.
    function automatic int unsigned cnt_w_for(input int unsigned mul_w);
        return (32 / mul_w > 1) ? $clog2(32 / mul_w) : 1;
    endfunction

    localparam int unsigned MUL_W_DFLT = 8;
    localparam int unsigned N_DFLT     = steps_for(MUL_W_DFLT);
    localparam int unsigned CNT_W_DFLT = cnt_w_for(MUL_W_DFLT);

endpackage

// File: rtl/xc_mmul_step.sv
// One multiply-accumulate step: o_acc = i_acc + i_mcand * i_chunk (mod 2^64).
// Purely combinational; the sequencer owns every register.
module xc_mmul_step
    import xc_mmul_pkg::*;
#(
    parameter int unsigned MUL_W = MUL_W_DFLT
) (
    input  logic [63:0]      i_acc,
    input  logic [63:0]      i_mcand,
    input  logic [MUL_W-1:0] i_chunk,
    output logic [63:0]      o_acc
);

    logic [63:0] w_pp;

    // The shifted multiplicand never carries rs1 bits past bit 63, so the truncated product is exact.
    assign w_pp  = i_mcand * {{(64 - MUL_W){1'b0}}, i_chunk};
    assign o_acc = i_acc + w_pp;

endmodule

// File: rtl/xc_mmul_seq.sv
// Multi-cycle sequencer for xc.mmul.3: {hi,lo} = rs1 * rs2 + (req_acc ? rs3 : 0), MUL_W bits per step.
// Optional XC_MMUL_SEQ_EARLY_TERM_EN ends RUN once the remaining multiplier is zero (not constant-time).
module xc_mmul_seq
    import xc_mmul_pkg::*;
#(
    parameter int unsigned MUL_W = MUL_W_DFLT
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_acc,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        busy
);

    localparam int unsigned N     = steps_for(MUL_W);
    localparam int unsigned CNT_W = cnt_w_for(MUL_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (!mul_w_legal(MUL_W)) begin : g_bad_mul_w
        $error("xc_mmul_seq: MUL_W must be 1, 2, 4, 8, 16 or 32");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [63:0]      r_mcand;
    logic [31:0]      r_mplier;
    logic [63:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [63:0]      w_acc_nxt;
    logic [31:0]      w_mplier_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    assign w_accept     = (r_state == ST_IDLE) && req_valid && !flush;
    assign w_step       = (r_state == ST_RUN) && !flush;
    assign w_mplier_nxt = r_mplier >> MUL_W;

`ifdef XC_MMUL_SEQ_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_LAST) || (w_mplier_nxt == 32'd0);
`else
    assign w_last = (r_cnt == CNT_LAST);
`endif

    xc_mmul_step #(
        .MUL_W (MUL_W)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_chunk (r_mplier[MUL_W-1:0]),
        .o_acc   (w_acc_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (flush || rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset because the result ports must read zero out of reset.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= {32'd0, req_rs1};
            r_mplier <= req_rs2;
            r_acc    <= req_acc ? {32'd0, req_rs3} : 64'd0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_W;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_lo    = r_acc[31:0];
    assign rsp_hi    = r_acc[63:32];

endmodule

// File: tb/tb_xc_mmul_seq.sv
// Self-checking bench for xc_mmul_seq: vector table, hand-written corner sequences, random ops vs a model.
// Expected latency follows XC_MMUL_SEQ_EARLY_TERM_EN when the bench is built with that macro.
module tb_xc_mmul_seq;

    localparam int unsigned MUL_W = 8;
    localparam int          N     = 32 / MUL_W;
`ifdef XC_MMUL_SEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_acc;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_rs3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        busy;

    xc_mmul_seq #(
        .MUL_W (MUL_W)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_acc   (req_acc),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_rs3   (req_rs3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
        .busy      (busy)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        acc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Reference model: the architectural result and the number of RUN cycles.
    function automatic logic [63:0] ref_result(input logic acc, input logic [31:0] rs1,
                                               input logic [31:0] rs2, input logic [31:0] rs3);
        return ({32'd0, rs1} * {32'd0, rs2}) + (acc ? {32'd0, rs3} : 64'd0);
    endfunction

    function automatic int ref_run_cycles(input logic [31:0] rs2);
        if (!EARLY) return N;
        for (int k = N; k >= 1; k--) begin
            if ((rs2 >> ((k - 1) * MUL_W)) != 32'd0) return k;
        end
        return 1;
    endfunction

    task automatic rand_req();
        req_acc = 1'($urandom_range(0, 1));
        req_rs1 = $urandom;
        req_rs2 = $urandom;
        req_rs3 = $urandom;
    endtask

    // Called in cycle 1 after an accept; returns the cycle index in which rsp_valid is first seen.
    task automatic wait_rsp(input bit scramble, output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            if (scramble) rand_req();
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic acc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] rs3, input logic [63:0] exp);
        int cyc;
        check({name, "/ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_acc   = acc;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rs3   = rs3;
        tick();
        req_valid = 1'b0;
        rand_req();
        wait_rsp(1'b0, cyc);
        check({name, "/lat"}, 64'(cyc), 64'(ref_run_cycles(rs2) + 1));
        check({name, "/res"}, {rsp_hi, rsp_lo}, exp);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, "/idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          seen;
        logic        a;
        logic [31:0] v1, v2, v3;

        vecs[0] = '{1'b1, 32'd3,         32'd5,         32'd7,         64'h0000_0000_0000_0016};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{1'b1, 32'd2,         32'd2,         32'd1,         64'd5};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'd1,         32'd0,         64'h0000_0000_1234_5678};
        vecs[5] = '{1'b1, 32'd0,         32'd0,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'hDEAD_BEEF, 64'h0000_0001_0000_0000};

        g_resetn  = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_acc   = 1'b0;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;
        req_rs3   = 32'd0;

        #2;
        check("reset/req_ready", 64'(req_ready), 64'd1);
        check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset/busy",      64'(busy),      64'd0);
        check("reset/result",    {rsp_hi, rsp_lo}, 64'd0);
        tick();
        tick();
        g_resetn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].acc, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].exp);
        end

        // Response held for 10 cycles while the request side keeps changing.
        req_valid = 1'b1;
        req_acc   = 1'b1;
        req_rs1   = 32'd3;
        req_rs2   = 32'd5;
        req_rs3   = 32'd7;
        tick();
        wait_rsp(1'b1, cyc);
        check("hold/lat", 64'(cyc), 64'(ref_run_cycles(32'd5) + 1));
        for (int i = 0; i < 10; i++) begin
            rand_req();
            tick();
            check($sformatf("hold%0d/rsp_valid", i), 64'(rsp_valid), 64'd1);
            check($sformatf("hold%0d/result", i), {rsp_hi, rsp_lo}, 64'h16);
            check($sformatf("hold%0d/req_ready", i), 64'(req_ready), 64'd0);
        end
        req_acc   = 1'b0;
        req_rs1   = 32'd9;
        req_rs2   = 32'd9;
        req_rs3   = $urandom;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold/consumed_ready", 64'(req_ready), 64'd1);
        check("hold/consumed_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("hold/accepted_busy", 64'(busy), 64'd1);
        req_valid = 1'b0;
        wait_rsp(1'b0, cyc);
        check("hold/next_lat", 64'(cyc), 64'(ref_run_cycles(32'd9) + 1));
        check("hold/next_res", {rsp_hi, rsp_lo}, 64'd81);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Flush during RUN cycle 2.
        req_valid = 1'b1;
        req_acc   = 1'b1;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'hCAFE_F00D;
        req_rs3   = 32'h0000_1234;
        tick();
        req_valid = 1'b0;
        tick();
        check("flush/in_run", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush/busy",      64'(busy),      64'd0);
        check("flush/req_ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("flush/no_rsp", 64'(seen), 64'd0);
        run_op("flush/next", 1'b1, 32'd2, 32'd2, 32'd1, 64'd5);

        // Flush in IDLE blocks a coincident request.
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle/busy", 64'(busy), 64'd0);

        // Flush in DONE together with rsp_ready.
        req_valid = 1'b1;
        req_acc   = 1'b1;
        req_rs1   = 32'd3;
        req_rs2   = 32'd5;
        req_rs3   = 32'd7;
        tick();
        req_valid = 1'b0;
        wait_rsp(1'b0, cyc);
        check("flush_done/valid", 64'(rsp_valid), 64'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        flush     = 1'b0;
        rsp_ready = 1'b0;
        check("flush_done/busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN.
        req_valid = 1'b1;
        req_acc   = 1'b1;
        req_rs1   = 32'h1111_1111;
        req_rs2   = 32'h2222_2222;
        req_rs3   = 32'h0000_0033;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        g_resetn = 1'b0;
        #1;
        check("arst/req_ready", 64'(req_ready), 64'd1);
        check("arst/rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst/busy",      64'(busy),      64'd0);
        check("arst/result",    {rsp_hi, rsp_lo}, 64'd0);
        tick();
        g_resetn = 1'b1;
        tick();
        check("arst/ready_after", 64'(req_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("arst/no_rsp", 64'(seen), 64'd0);
        run_op("arst/next", 1'b0, 32'h1234_5678, 32'd1, 32'd0, 64'h1234_5678);

        // Random operations against the model; small multipliers exercise early termination.
        for (int i = 0; i < 40; i++) begin
            a  = 1'($urandom_range(0, 1));
            v1 = $urandom;
            v2 = $urandom >> $urandom_range(0, 31);
            v3 = $urandom;
            run_op($sformatf("rand%0d", i), a, v1, v2, v3, ref_result(a, v1, v2, v3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
